// File: rtl/ins_queue_if.sv
// Fetch/decode side bundle of the instruction queue. slave is the queue's view,
// master is the view of whoever drives fetch and decode.
interface ins_queue_if #(
  parameter int DEPTH_LOG = 4
);
  // Handshakes: a push happens on an edge where fetch_valid=1 and the queue has
  // room (or pops in the same cycle); a pop happens on an edge where decode_flag=1
  // and decode_ok=1. Both are qualified by rdy_in, and clear overrides both.
  logic                 clear;
  logic                 fetch_valid;
  logic [31:0]          fetch_ins;
  logic [31:0]          fetch_pc;
  logic [31:0]          fetch_pred_pc;
  logic                 queue_full;
  logic                 decode_flag;
  logic [31:0]          ins;
  logic [31:0]          ins_pc;
  logic [31:0]          ins_pred_pc;
  logic                 decode_ok;
  logic [DEPTH_LOG:0]   count;
  logic                 overflow;
  logic [31:0]          stall_cnt;
  logic                 dbg_flush;

  modport slave (
    input  clear, fetch_valid, fetch_ins, fetch_pc, fetch_pred_pc, decode_ok,
    output queue_full, decode_flag, ins, ins_pc, ins_pred_pc, count, overflow,
           stall_cnt, dbg_flush
  );

  modport master (
    output clear, fetch_valid, fetch_ins, fetch_pc, fetch_pred_pc, decode_ok,
    input  queue_full, decode_flag, ins, ins_pc, ins_pred_pc, count, overflow,
           stall_cnt, dbg_flush
  );
endinterface

// File: rtl/ins_queue.sv
// Instruction buffer between fetch and decode: circular FIFO with mispredict
// flush, post-flush drop window and global pause.
module ins_queue #(
  parameter int DEPTH_LOG  = 4,
  parameter int SLACK      = 2,
  parameter int FLUSH_HOLD = 1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        rdy_in,
  ins_queue_if.slave  q
);
  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t FULL_TH = cnt_t'(DEPTH - SLACK);

  state_t      state_q, state_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic [2:0]  hold_q, hold_d;
  logic        overflow_q, overflow_d;
  logic [31:0] stall_q, stall_d;
  logic [95:0] mem_q [DEPTH];

  logic run, nonempty, flag, pop, push;

  assign run      = (state_q == ST_RUN);
  assign nonempty = (count_q != '0);
  assign flag     = rdy_in & run & nonempty;
  assign pop      = flag & q.decode_ok & ~q.clear;
  assign push     = rdy_in & run & ~q.clear & q.fetch_valid &
                    ((count_q != DEPTH_C) | pop);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    hold_d     = hold_q;
    overflow_d = overflow_q;
    stall_d    = stall_q;
    if (rdy_in) begin
      if (q.clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        hold_d  = 3'(FLUSH_HOLD);
        state_d = ST_FLUSH;
      end else if (run) begin
        head_d  = head_q + ptr_t'(pop);
        tail_d  = tail_q + ptr_t'(push);
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        if (q.fetch_valid && count_q == DEPTH_C && !pop)
          overflow_d = 1'b1;
      end else begin
        hold_d = hold_q - 3'd1;
        if (hold_q == 3'd1)
          state_d = ST_RUN;
      end
      // Stall accounting looks at the presented head even in a clearing cycle.
      if (flag && !q.decode_ok)
        stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
    end
  end

  // Entry payloads carry no reset; count gates everything read from them.
  always_ff @(posedge clk_in) begin
    if (push)
      mem_q[tail_q] <= {q.fetch_ins, q.fetch_pc, q.fetch_pred_pc};
  end

  logic [95:0] head_entry;
  assign head_entry = nonempty ? mem_q[head_q] : 96'd0;

  assign q.decode_flag = flag;
  assign q.ins         = head_entry[95:64];
  assign q.ins_pc      = head_entry[63:32];
  assign q.ins_pred_pc = head_entry[31:0];
  assign q.queue_full  = run & (count_q >= FULL_TH);
  assign q.count       = count_q;
  assign q.overflow    = overflow_q;
  assign q.stall_cnt   = stall_q;
  assign q.dbg_flush   = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_ins_queue.sv
// Directed bench for ins_queue: reset, pass-through, fill/overflow, full-rate
// wrap, flush drop window and pause.
module tb_ins_queue;
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic rdy_in = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  ins_queue_if #(.DEPTH_LOG(4)) bus ();

  ins_queue #(.DEPTH_LOG(4), .SLACK(2), .FLUSH_HOLD(1)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .rdy_in (rdy_in),
    .q      (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic ok,
                       input logic clr);
    bus.fetch_valid   = fv;
    bus.fetch_pc      = pc;
    bus.fetch_ins     = pc ^ 32'hA5A5_0000;
    bus.fetch_pred_pc = pc + 32'd4;
    bus.decode_ok     = ok;
    bus.clear         = clr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick();
    checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL rst_flag got %b want 0", bus.decode_flag); end
    checks++; if (bus.queue_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", bus.queue_full); end
    checks++; if (bus.ins !== 32'd0) begin errors++; $display("FAIL rst_ins got %h want 0", bus.ins); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL idle_count got %0d want 0", bus.count); end
    checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL idle_stall got %0d want 0", bus.stall_cnt); end
    checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL idle_flag got %b want 0", bus.decode_flag); end
  endtask

  task automatic test_pass_through();
    drive(1'b1, 32'd0, 1'b1, 1'b0);
    bus.fetch_ins     = 32'h0050_0093;
    bus.fetch_pred_pc = 32'd4;
    #1;
    checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL pt_flag0 got %b want 0", bus.decode_flag); end
    tick();
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (bus.decode_flag !== 1'b1) begin errors++; $display("FAIL pt_flag1 got %b want 1", bus.decode_flag); end
    checks++; if (bus.ins !== 32'h0050_0093) begin errors++; $display("FAIL pt_ins got %h want 00500093", bus.ins); end
    checks++; if (bus.ins_pc !== 32'd0) begin errors++; $display("FAIL pt_pc got %h want 0", bus.ins_pc); end
    checks++; if (bus.ins_pred_pc !== 32'd4) begin errors++; $display("FAIL pt_pred got %h want 4", bus.ins_pred_pc); end
    tick();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL pt_count got %0d want 0", bus.count); end
    checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL pt_stall got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      checks++; if (bus.count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count, i); end
      checks++; if (bus.queue_full !== (i >= 14)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, bus.queue_full, i >= 14); end
      exp_q.push_back(32'h100 + 32'(4 * i));
      tick();
    end
    drive(1'b1, 32'h1FC, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count16 got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf0 got %b want 0", bus.overflow); end
    checks++; if (bus.stall_cnt !== 32'd15) begin errors++; $display("FAIL fill_stall15 got %0d want 15", bus.stall_cnt); end
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", bus.count); end
    checks++; if (bus.stall_cnt !== 32'd16) begin errors++; $display("FAIL ovf_stall got %0d want 16", bus.stall_cnt); end
    checks++; if (bus.ins_pc !== 32'h100) begin errors++; $display("FAIL ovf_head got %h want 100", bus.ins_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      want = exp_q.pop_front();
      exp_q.push_back(32'h200 + 32'(4 * i));
      checks++; if (bus.ins_pc !== want) begin errors++; $display("FAIL b2b_pc[%0d] got %h want %h", i, bus.ins_pc, want); end
      tick();
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 16", i, bus.count); end
    end
    checks++; if (bus.stall_cnt !== 32'd16) begin errors++; $display("FAIL b2b_stall got %0d want 16", bus.stall_cnt); end
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      want = exp_q.pop_front();
      checks++; if (bus.ins_pc !== want) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", i, bus.ins_pc, want); end
      tick();
    end
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL drain_count got %0d want 5", bus.count); end
    // Asynchronous reset must empty the queue without waiting for an edge.
    rst_n = 1'b0;
    #1;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL arst_count got %0d want 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got %b want 0", bus.overflow); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h280 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h2F0, 1'b1, 1'b1);
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL fl_count5 got %0d want 5", bus.count); end
    checks++; if (bus.decode_flag !== 1'b1) begin errors++; $display("FAIL fl_flag_pre got %b want 1", bus.decode_flag); end
    tick();
    drive(1'b1, 32'h300, 1'b1, 1'b0);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL fl_count0 got %0d want 0", bus.count); end
    checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL fl_flag got %b want 0", bus.decode_flag); end
    checks++; if (bus.dbg_flush !== 1'b1) begin errors++; $display("FAIL fl_state got %b want 1", bus.dbg_flush); end
    tick();
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL fl_drop got %0d want 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fl_ovf got %b want 0", bus.overflow); end
    checks++; if (bus.dbg_flush !== 1'b0) begin errors++; $display("FAIL fl_run got %b want 0", bus.dbg_flush); end
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL fl_accept got %0d want 1", bus.count); end
    checks++; if (bus.ins_pc !== 32'h304) begin errors++; $display("FAIL fl_head got %h want 304", bus.ins_pc); end
    checks++; if (bus.stall_cnt !== 32'd4) begin errors++; $display("FAIL fl_stall got %0d want 4", bus.stall_cnt); end
    tick();
  endtask

  task automatic test_pause();
    drive(1'b1, 32'h308, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h30C, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rdy_in = 1'b0;
      drive(1'b1, 32'h400, 1'b1, (i == 2));
      checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL pz_flag[%0d] got %b want 0", i, bus.decode_flag); end
      tick();
    end
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL pz_count got %0d want 3", bus.count); end
    checks++; if (bus.stall_cnt !== 32'd7) begin errors++; $display("FAIL pz_stall got %0d want 7", bus.stall_cnt); end
    rdy_in = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (bus.decode_flag !== 1'b1) begin errors++; $display("FAIL pz_resume got %b want 1", bus.decode_flag); end
    checks++; if (bus.ins_pc !== 32'h304) begin errors++; $display("FAIL pz_head got %h want 304", bus.ins_pc); end
    tick();
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL pz_pop got %0d want 2", bus.count); end
    checks++; if (bus.ins_pc !== 32'h308) begin errors++; $display("FAIL pz_next got %h want 308", bus.ins_pc); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill();
    test_back_to_back();
    test_flush();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
